// File: rtl/comms_rx_unpacker_if.sv
// rtl/comms_rx_unpacker_if.sv - payload byte stream between the rx unpacker and its consumer
interface comms_rx_unpacker_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/comms_rx_unpacker.sv
// rtl/comms_rx_unpacker.sv - captures the link rx buffer, validates sync/length/checksum, streams payload
// Optional err_count output enabled by COMMS_RX_UNPACK_ERRCNT_EN.
module comms_rx_unpacker #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         MAX_LEN     = 29,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [255:0]             rx_buffer,
  input  logic                     rx_new,
  comms_rx_unpacker_if.master      outIf,
  output logic                     frame_ok,
  output logic                     frame_err,
  output logic [1:0]               err_code,
  output logic                     overrun,
  output logic                     busy
`ifdef COMMS_RX_UNPACK_ERRCNT_EN
  ,
  output logic [15:0]              err_count
`endif
);

  typedef enum logic [2:0] {IDLE, HDR, SUM, CMP, EMIT, DONE, ERR} state_t;
  state_t state, nextState;

  logic [SYNC_STAGES-1:0] syncQ;
  logic                   edgeQ;
  logic                   newEdge;
  logic [255:0]           frameQ;
  logic [7:0]             accQ;
  logic [4:0]             idxQ;
  logic                   validQ;

  logic [7:0] lenByte;
  logic [7:0] payByte;
  logic [7:0] chkByte;
  logic       lenBad;
  logic       lastIdx;
  logic       handshake;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      syncQ <= '0;
      edgeQ <= 1'b0;
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], rx_new};
      edgeQ <= syncQ[SYNC_STAGES-1];
    end
  end

  assign newEdge = syncQ[SYNC_STAGES-1] & ~edgeQ;

  // Payload index never exceeds 28 and len is range-checked before the checksum
  // byte is read, so both selects stay inside the 32-byte frame.
  assign lenByte   = frameQ[15:8];
  assign payByte   = frameQ[{idxQ + 5'd2, 3'b000} +: 8];
  assign chkByte   = frameQ[{lenByte[4:0] + 5'd2, 3'b000} +: 8];
  assign lenBad    = (lenByte == 8'd0) || (lenByte > 8'(MAX_LEN));
  assign lastIdx   = ({3'b000, idxQ} == (lenByte - 8'd1));
  assign handshake = validQ & outIf.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (newEdge) nextState = HDR;
      HDR:     nextState = ((frameQ[7:0] != SYNC_BYTE) || lenBad) ? ERR : SUM;
      SUM:     if (lastIdx) nextState = CMP;
      CMP:     nextState = (accQ == chkByte) ? EMIT : ERR;
      EMIT:    if (handshake && lastIdx) nextState = DONE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frameQ   <= '0;
      accQ     <= '0;
      idxQ     <= '0;
      err_code <= '0;
      validQ   <= 1'b0;
    end else begin
      validQ <= (nextState == EMIT);
      case (state)
        IDLE: if (newEdge) frameQ <= rx_buffer;
        HDR: begin
          accQ <= lenByte;
          idxQ <= '0;
          if (frameQ[7:0] != SYNC_BYTE) begin
            err_code <= 2'b01;
          end else if (lenBad) begin
            err_code <= 2'b10;
          end
        end
        SUM: begin
          accQ <= accQ + payByte;
          idxQ <= idxQ + 5'd1;
        end
        CMP: begin
          idxQ <= '0;
          if (accQ != chkByte) err_code <= 2'b11;
        end
        EMIT: if (handshake) idxQ <= idxQ + 5'd1;
        default: ;
      endcase
    end
  end

  assign outIf.out_valid = validQ;

  // An edge seen outside IDLE (including the DONE/ERR exit cycle) is a dropped frame.
  always_comb begin
    busy           = (state != IDLE);
    frame_ok       = (state == DONE);
    frame_err      = (state == ERR);
    overrun        = newEdge && (state != IDLE);
    outIf.out_data = (state == EMIT) ? payByte : 8'h00;
    outIf.out_last = (state == EMIT) && lastIdx;
  end

`ifdef COMMS_RX_UNPACK_ERRCNT_EN
  logic [16:0] errSum;
  assign errSum = {1'b0, err_count} + {16'd0, frame_err} + {16'd0, overrun};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
    end else begin
      err_count <= errSum[16] ? 16'hFFFF : errSum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_comms_rx_unpacker.sv
// tb/tb_comms_rx_unpacker.sv - randomized and directed frames checked against a frame-level model
module tb_comms_rx_unpacker;
  logic         clk;
  logic         rst;
  logic [255:0] rx_buffer;
  logic         rx_new;
  logic         frame_ok;
  logic         frame_err;
  logic [1:0]   err_code;
  logic         overrun;
  logic         busy;
`ifdef COMMS_RX_UNPACK_ERRCNT_EN
  logic [15:0]  err_count;
`endif

  comms_rx_unpacker_if outIf ();

  comms_rx_unpacker dut (
    .clk       (clk),
    .rst       (rst),
    .rx_buffer (rx_buffer),
    .rx_new    (rx_new),
    .outIf     (outIf),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .err_code  (err_code),
    .overrun   (overrun),
    .busy      (busy)
`ifdef COMMS_RX_UNPACK_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nChecks = 0;
  int nFail   = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame-level model state
  logic [7:0] expQ[$];
  logic [7:0] log[$];
  bit         active = 0;
  logic [1:0] expCode;
  int startCyc, firstValidCyc, errCyc, endCyc;
  int okCyc  = -1;
  int ovrCyc = -1;
  int expCnt = 0;
  int okSeen = 0, errSeen = 0, ovrSeen = 0, okSeenCyc = 0;
  bit expValid, expBusy;

  int readyMode = 0;
  int lowFrom = 1 << 30;
  int lowTo   = 1 << 30;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] modelSum(input logic [255:0] b);
    int len = int'(b[15:8]);
    int s = len;
    for (int i = 0; i < len && i < 30; i++) s += int'(b[8*(2+i) +: 8]);
    return 8'(s % 256);
  endfunction

  function automatic logic [1:0] classify(input logic [255:0] b);
    int len = int'(b[15:8]);
    if (b[7:0] != 8'hA5) return 2'b01;
    if (len == 0 || len > 29) return 2'b10;
    if (modelSum(b) != b[8*(2+len) +: 8]) return 2'b11;
    return 2'b00;
  endfunction

  always @(posedge clk) begin
    #2;
    case (readyMode)
      0:       outIf.out_ready = 1'b1;
      1:       outIf.out_ready = ($urandom_range(3) != 0);
      default: outIf.out_ready = !(cyc >= lowFrom && cyc <= lowTo);
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", outIf.out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_ok", frame_ok, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_err_code", err_code, 0);
`ifdef COMMS_RX_UNPACK_ERRCNT_EN
      chk("rst_err_count", err_count, 0);
`endif
    end else begin
      expValid = active && expCode == 2'b00 && cyc >= firstValidCyc && expQ.size() > 0;
      chk("out_valid", outIf.out_valid, expValid);
      if (expValid && outIf.out_valid) begin
        chk("out_data", outIf.out_data, expQ[0]);
        chk("out_last", outIf.out_last, expQ.size() == 1);
        if (outIf.out_ready) begin
          log.push_back(expQ.pop_front());
          if (expQ.size() == 0) okCyc = cyc + 1;
        end
      end
      chk("frame_ok", frame_ok, active && expCode == 2'b00 && cyc == okCyc);
      chk("frame_err", frame_err, active && expCode != 2'b00 && cyc == errCyc);
      if (active && expCode != 2'b00 && cyc == errCyc) chk("err_code", err_code, expCode);
      chk("overrun", overrun, cyc == ovrCyc);
      endCyc  = (expCode != 2'b00) ? errCyc : ((okCyc >= 0) ? okCyc : (1 << 30));
      expBusy = active && cyc >= startCyc + 3 && cyc <= endCyc;
      chk("busy", busy, expBusy);
`ifdef COMMS_RX_UNPACK_ERRCNT_EN
      chk("err_count", err_count, expCnt);
      if (active && expCode != 2'b00 && cyc == errCyc) expCnt++;
      if (cyc == ovrCyc) expCnt++;
`endif
      if (frame_ok) begin
        okSeen++;
        okSeenCyc = cyc;
      end
      if (frame_err) errSeen++;
      if (overrun) ovrSeen++;
      if (active && cyc == endCyc) active = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitCyc(input int target);
    while (cyc < target) step(1);
  endtask

  task automatic waitIdle();
    int n = 0;
    while (active && n < 3000) begin
      step(1);
      n++;
    end
    chk("frame_timeout", active, 0);
  endtask

  task automatic sendFrame(input logic [255:0] b, input int hold);
    logic [1:0] code;
    int len;
    code = classify(b);
    len  = int'(b[15:8]);
    rx_buffer = b;
    rx_new    = 1'b1;
    startCyc      = cyc;
    expCode       = code;
    okCyc         = -1;
    firstValidCyc = startCyc + 5 + len;
    errCyc        = (code == 2'b01 || code == 2'b10) ? startCyc + 4 : startCyc + 5 + len;
    expQ.delete();
    log.delete();
    if (code == 2'b00) for (int i = 0; i < len; i++) expQ.push_back(b[8*(2+i) +: 8]);
    active = 1;
    step(hold);
    rx_new = 1'b0;
  endtask

  task automatic raiseOverrun(input int atCyc);
    waitCyc(atCyc);
    rx_buffer = {$urandom(), $urandom(), $urandom(), $urandom(),
                 $urandom(), $urandom(), $urandom(), $urandom()};
    rx_new = 1'b1;
    ovrCyc = cyc + 2;
    step(2);
    rx_new = 1'b0;
  endtask

  function automatic logic [255:0] mkGood(input int len);
    logic [255:0] b;
    for (int w = 0; w < 8; w++) b[32*w +: 32] = $urandom();
    b[7:0]  = 8'hA5;
    b[15:8] = 8'(len);
    b[8*(2+len) +: 8] = modelSum(b);
    return b;
  endfunction

  initial begin
    logic [255:0] b;
    logic [255:0] goodF;
    logic [255:0] maxF;
    int o0, e0, v0, len, kind;
    logic [1:0] code;
    logic [7:0] s;

    rst = 1'b1;
    rx_new = 1'b0;
    rx_buffer = '0;
    outIf.out_ready = 1'b0;
    step(3);
    rst = 1'b0;
    step(2);

    goodF = 256'h6933221103A5;
    maxF  = '0;
    maxF[7:0]  = 8'hA5;
    maxF[15:8] = 8'd29;
    for (int i = 0; i < 29; i++) maxF[8*(2+i) +: 8] = 8'hFF;
    maxF[255:248] = 8'h00;

    // Hand-computed checksums and verdicts pin the model
    chk("pin_sum_good", modelSum(goodF), 8'h69);
    chk("pin_sum_max", modelSum(maxF), 8'h00);
    chk("pin_sum_bad", modelSum(256'h0002FF02A5), 8'h03);
    chk("pin_cls_good", classify(goodF), 2'b00);
    chk("pin_cls_sync", classify(256'h5A), 2'b01);
    chk("pin_cls_len", classify(256'h00A5), 2'b10);
    chk("pin_cls_sum", classify(256'h0002FF02A5), 2'b11);

    // Good frame, always ready
    o0 = okSeen; e0 = errSeen;
    sendFrame(goodF, 3);
    waitIdle();
    chk("good_count", log.size(), 3);
    if (log.size() == 3) begin
      chk("good_b0", log[0], 8'h11);
      chk("good_b1", log[1], 8'h22);
      chk("good_b2", log[2], 8'h33);
    end
    chk("good_ok", okSeen - o0, 1);
    chk("good_err", errSeen - e0, 0);
    chk("good_ok_latency", okSeenCyc - startCyc, 11);
    step(3);

    // Backpressure while 22 is presented
    readyMode = 2;
    lowFrom = cyc + 9;
    lowTo   = cyc + 11;
    o0 = okSeen;
    sendFrame(goodF, 3);
    waitIdle();
    chk("bp_count", log.size(), 3);
    chk("bp_ok", okSeen - o0, 1);
    chk("bp_ok_latency", okSeenCyc - startCyc, 14);
    readyMode = 0;
    step(3);

    // Three rejected frames
    e0 = errSeen;
    sendFrame(256'h5A, 3);
    waitIdle();
    step(3);
    sendFrame(256'h00A5, 3);
    waitIdle();
    step(3);
    sendFrame(256'h0002FF02A5, 3);
    waitIdle();
    step(3);
    chk("err_pulses", errSeen - e0, 3);

    // Maximum length with checksum wrap
    sendFrame(maxF, 3);
    waitIdle();
    chk("max_count", log.size(), 29);
    step(3);

    // Overrun during EMIT leaves the current frame intact
    b = mkGood(5);
    v0 = ovrSeen; o0 = okSeen;
    sendFrame(b, 3);
    raiseOverrun(startCyc + 9);
    waitIdle();
    chk("ovr_pulses", ovrSeen - v0, 1);
    chk("ovr_ok", okSeen - o0, 1);
    chk("ovr_count", log.size(), 5);
    for (int i = 0; i < 5 && i < log.size(); i++) chk("ovr_payload", log[i], b[8*(2+i) +: 8]);
    step(3);

    // Edge landing on the ERR exit cycle counts as overrun and is not captured
    v0 = ovrSeen; e0 = errSeen;
    sendFrame(256'h5A, 1);
    step(1);
    rx_new = 1'b1;
    ovrCyc = cyc + 2;
    step(2);
    rx_new = 1'b0;
    waitIdle();
    step(4);
    chk("errx_ovr", ovrSeen - v0, 1);
    chk("errx_err", errSeen - e0, 1);
    chk("errx_idle", busy, 0);

    // Reset during SUM
    o0 = okSeen; e0 = errSeen;
    sendFrame(mkGood(10), 3);
    waitCyc(startCyc + 5);
    rst = 1'b1;
    active = 0;
    ovrCyc = -1;
    expQ.delete();
    expCnt = 0;
    step(2);
    rst = 1'b0;
    step(20);
    chk("rst_no_status", (okSeen - o0) + (errSeen - e0), 0);

    // Randomized frames with random backpressure and occasional overruns
    readyMode = 1;
    for (int f = 0; f < 40; f++) begin
      for (int w = 0; w < 8; w++) b[32*w +: 32] = $urandom();
      kind = $urandom_range(5);
      b[7:0] = 8'hA5;
      if (kind == 3) begin
        b[7:0] = 8'hA5 ^ 8'($urandom_range(255, 1));
      end else if (kind == 4) begin
        b[15:8] = ($urandom_range(1) == 0) ? 8'd0 : 8'($urandom_range(255, 30));
      end else begin
        len = $urandom_range(29, 1);
        b[15:8] = 8'(len);
        s = modelSum(b);
        b[8*(2+len) +: 8] = (kind == 5) ? s + 8'($urandom_range(255, 1)) : s;
      end
      code = classify(b);
      len  = int'(b[15:8]);
      sendFrame(b, 3);
      if ((code == 2'b00 || code == 2'b11) && $urandom_range(2) == 0)
        raiseOverrun(startCyc + 4 + $urandom_range(len - 1));
      waitIdle();
      step(3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks %0d failures", nChecks, nFail);
    $fatal(1);
  end

endmodule
